// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// SERIAL_ADDER_SUB_EN adds the sub select.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );
  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );
`else
  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );
  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder stage sequenced over WIDTH cycles.
// Define SERIAL_ADDER_SUB_EN to enable a-b via the sub select.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus,
  output logic                busy
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] s_sr;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             co_q;
  logic             ovf_q;
  logic             ready_q;
  logic             valid_q;
  logic             busy_q;

  logic             fa_s;
  logic             fa_c;
  logic             last;
  logic [WIDTH-1:0] s_nxt;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;

  always_comb begin
    fa_s  = a_sr[0] ^ b_sr[0] ^ carry;
    fa_c  = (a_sr[0] & b_sr[0])
          | (a_sr[0] & carry)
          | (b_sr[0] & carry);
    last  = (cnt == CW'(WIDTH - 1));
    s_nxt = {fa_s, s_sr};
`ifdef SERIAL_ADDER_SUB_EN
    b_ld  = bus.sub ? ~bus.b : bus.b;
    c_ld  = bus.sub | bus.ci;
`else
    b_ld  = bus.b;
    c_ld  = bus.ci;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      s_sr    <= '0;
      sum_q   <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr    <= bus.a;
            b_sr    <= b_ld;
            carry   <= c_ld;
            cnt     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= s_nxt[WIDTH-1:1];
          carry <= fa_c;
          if (!last) begin
            cnt <= cnt + 1'b1;
          end else begin
            // carry still holds the carry into the MSB here
            sum_q   <= s_nxt;
            co_q    <= fa_c;
            ovf_q   <= carry ^ fa_c;
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ready_q & ~rst;
  assign bus.out_valid = valid_q;
  assign bus.sum       = sum_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl, WIDTH=8.
// Directed vectors; monitor pops expectations on result handshakes.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  exp_t q[$];
  int   pass_cnt = 0;
  int   total = 0;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      exp_t e;
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else if (bus.out_ready) begin
        e = q.pop_front();
        chk("sum", bus.sum, e.s);
        chk("co", bus.co, e.co);
        chk("ovf", bus.ovf, e.ov);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sub, input bit push,
                       input logic [W-1:0] es, input logic eco,
                       input logic eov);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.a  = a;
    bus.b  = b;
    bus.ci = ci;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = sub;
`else
    if (sub) $display("note: sub vector without SUB build");
`endif
    if (push) q.push_back('{es, eco, eov});
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.out_valid && n < W + 5) begin
      tick();
      n++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sub,
                        input logic [W-1:0] es, input logic eco,
                        input logic eov);
    issue(a, b, ci, sub, 1'b1, es, eco, eov);
    wait_valid();
    tick();
  endtask

  initial begin
    int lat;
    int n;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a  = '0;
    bus.b  = '0;
    bus.ci = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b0;
`endif
    repeat (2) tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", {bus.sum, bus.co, bus.ovf}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // basic add with latency
    issue(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    chk("busy_after_accept", busy, 1);
    chk("in_ready_run", bus.in_ready, 0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", lat, W);
    tick();
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_out_valid", bus.out_valid, 0);
    chk("idle_sum_held", bus.sum, 8'h10);
    chk("idle_busy", busy, 0);

    run_op(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // backpressure with new operands offered in DONE
    bus.out_ready = 1'b0;
    issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.a = 8'hAA;
      bus.b = 8'h11;
      tick();
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_result", {bus.sum, bus.co, bus.ovf}, {8'h46, 2'b00});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", bus.in_ready, 1);
    chk("bp_release_out_valid", bus.out_valid, 0);
    chk("bp_release_sum", bus.sum, 8'h46);
    repeat (W + 4) tick();
    chk("bp_no_accept_busy", busy, 0);

    // reset during RUN aborts
    issue(8'h55, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum", bus.sum, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    repeat (W + 4) tick();
    chk("abort_quiet", bus.out_valid, 0);
    run_op(8'h55, 8'h33, 1'b0, 1'b0, 8'h88, 1'b0, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op(8'h30, 8'h10, 1'b1, 1'b0, 8'h41, 1'b0, 1'b0);
`endif

    n = 0;
    while (q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    if (q.size() != 0) chk("queue_drain", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
